fp_div_seq: RTL



---
 rtl/fp_div_seq.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/fp_div_seq.sv
// fp_div_seq: iterative floating-point divider, one quotient bit per cycle.
// It uses the same {sign, exponent, mantissa} format, bias and flag meanings
// as the combinational FP multiplier it pairs with.
//
// Ports:
//   clk, rst              single clock, synchronous active-high reset
//   in_valid/in_ready     operand handshake (in_a dividend, in_b divisor)
//   out_valid/out_ready   result handshake (out_x quotient plus flags)
//   overflow              result saturated to all-ones
//   underflow             result flushed to signed zero
//   exception             an operand had an all-ones exponent
//   div_by_zero           divisor exponent was zero
//
// Flags are only meaningful while out_valid is high. They are cleared on the
// pop edge.
module fp_div_seq #(
   parameter int unsigned W_MANTISSA = 8,
   parameter int unsigned W_EXPONENT = 8,
   localparam int unsigned W_FP_NUMBER = W_MANTISSA + W_EXPONENT + 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [W_FP_NUMBER-1:0] in_a,
   input  logic [W_FP_NUMBER-1:0] in_b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [W_FP_NUMBER-1:0] out_x,
   output logic                   overflow,
   output logic                   underflow,
   output logic                   exception,
   output logic                   div_by_zero
);

   localparam int unsigned W_Q   = W_MANTISSA + 3;  // quotient bits, MSB is the integer bit
   localparam int unsigned W_SIG = W_MANTISSA + 1;  // significand with hidden bit
   localparam int unsigned W_E2  = W_EXPONENT + 2;  // signed exponent working width
   localparam int unsigned W_CNT = $clog2(W_Q);
   localparam int unsigned BIAS  = (2 ** (W_EXPONENT - 1)) - 1;

   localparam logic signed [W_E2-1:0] E_BIAS = W_E2'(BIAS);
   localparam logic signed [W_E2-1:0] E_MAX  = W_E2'((2 ** W_EXPONENT) - 1);
   localparam logic signed [W_E2-1:0] E_ONE  = W_E2'(1);

   typedef enum logic [1:0] {StIdle, StDiv, StRound, StDone} state_t;
   // Result class, decided from the raw operands on the accept edge.
   typedef enum logic [1:0] {SpNone, SpExc, SpDbz, SpZero} spec_t;

   state_t state_q, state_d;

   logic                   sign_q;
   logic signed [W_E2-1:0] e_tmp_q;
   logic [W_Q-1:0]         rem_q;
   logic [W_SIG-1:0]       div_q;
   logic [W_Q-1:0]         q_q;
   logic [W_CNT-1:0]       cnt_q;
   spec_t                  spec_q;

   logic [W_FP_NUMBER-1:0] out_x_q;
   logic                   ovf_q, unf_q, exc_q, dbz_q;

   // ---------------- operand decode ----------------
   logic [W_EXPONENT-1:0]  a_exp, b_exp;
   logic [W_MANTISSA-1:0]  a_man, b_man;
   logic                   sign_in;
   logic signed [W_E2-1:0] e_in;
   spec_t                  spec_in;

   always_comb begin
      a_exp   = in_a[W_FP_NUMBER-2 -: W_EXPONENT];
      b_exp   = in_b[W_FP_NUMBER-2 -: W_EXPONENT];
      a_man   = in_a[W_MANTISSA-1:0];
      b_man   = in_b[W_MANTISSA-1:0];
      sign_in = in_a[W_FP_NUMBER-1] ^ in_b[W_FP_NUMBER-1];
      e_in    = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + E_BIAS;
      if ((&a_exp) || (&b_exp)) begin
         spec_in = SpExc;
      end else if (~|b_exp) begin
         spec_in = SpDbz;
      end else if (~|a_exp) begin
         spec_in = SpZero;
      end else begin
         spec_in = SpNone;
      end
   end

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         StIdle: begin
            in_ready = 1'b1;
            // Special cases skip the divide and only pass through the
            // output register stage.
            if (in_valid) begin
               state_d = (spec_in == SpNone) ? StDiv : StRound;
            end
         end
         StDiv: begin
            if (cnt_q == W_CNT'(W_Q - 1)) begin
               state_d = StRound;
            end
         end
         StRound: begin
            state_d = StDone;
         end
         StDone: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // ---------------- restoring divide step ----------------
   logic [W_Q:0]   rem_sub;
   logic           rem_ge;
   logic [W_Q-1:0] rem_keep, rem_d, q_d;

   always_comb begin
      rem_sub  = {1'b0, rem_q} - {{(W_Q + 1 - W_SIG){1'b0}}, div_q};
      rem_ge   = ~rem_sub[W_Q];
      rem_keep = rem_ge ? rem_sub[W_Q-1:0] : rem_q;
      rem_d    = rem_keep << 1;
      q_d      = {q_q[W_Q-2:0], rem_ge};
   end

   // ---------------- normalize, round, range check ----------------
   logic [W_MANTISSA-1:0]  man_pre;
   logic [W_MANTISSA:0]    man_sum;
   logic                   g_bit, s_bit, rem_nz;
   logic signed [W_E2-1:0] e_norm, e_fin;
   logic [W_FP_NUMBER-1:0] res_x;
   logic                   res_ovf, res_unf, res_exc, res_dbz;

   always_comb begin
      rem_nz = |rem_q;
      if (q_q[W_Q-1]) begin
         man_pre = q_q[W_Q-2 -: W_MANTISSA];
         g_bit   = q_q[1];
         s_bit   = q_q[0] | rem_nz;
         e_norm  = e_tmp_q;
      end else begin
         man_pre = q_q[W_Q-3 -: W_MANTISSA];
         g_bit   = q_q[0];
         s_bit   = rem_nz;
         e_norm  = e_tmp_q - E_ONE;
      end
      // Ties truncate: only G & S rounds up. A carry leaves the mantissa at 0.
      man_sum = {1'b0, man_pre} + {{W_MANTISSA{1'b0}}, g_bit & s_bit};
      e_fin   = man_sum[W_MANTISSA] ? e_norm + E_ONE : e_norm;

      res_x   = '0;
      res_ovf = 1'b0;
      res_unf = 1'b0;
      res_exc = 1'b0;
      res_dbz = 1'b0;
      unique case (spec_q)
         SpExc: begin
            res_exc = 1'b1;
         end
         SpDbz: begin
            res_dbz = 1'b1;
            res_x   = {sign_q, {(W_FP_NUMBER - 1){1'b1}}};
         end
         SpZero: begin
            res_x = {sign_q, {(W_FP_NUMBER - 1){1'b0}}};
         end
         default: begin
            if (e_fin >= E_MAX) begin
               res_ovf = 1'b1;
               res_x   = {sign_q, {(W_FP_NUMBER - 1){1'b1}}};
            end else if (e_fin <= $signed(W_E2'(0))) begin
               res_unf = 1'b1;
               res_x   = {sign_q, {(W_FP_NUMBER - 1){1'b0}}};
            end else begin
               res_x = {sign_q, e_fin[W_EXPONENT-1:0], man_sum[W_MANTISSA-1:0]};
            end
         end
      endcase
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         sign_q  <= 1'b0;
         e_tmp_q <= '0;
         rem_q   <= '0;
         div_q   <= '0;
         q_q     <= '0;
         cnt_q   <= '0;
         spec_q  <= SpNone;
         out_x_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         exc_q   <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  sign_q  <= sign_in;
                  e_tmp_q <= e_in;
                  rem_q   <= {{(W_Q - W_SIG){1'b0}}, 1'b1, a_man};
                  div_q   <= {1'b1, b_man};
                  q_q     <= '0;
                  cnt_q   <= '0;
                  spec_q  <= spec_in;
               end
            end
            StDiv: begin
               rem_q <= rem_d;
               q_q   <= q_d;
               cnt_q <= cnt_q + W_CNT'(1);
            end
            StRound: begin
               out_x_q <= res_x;
               ovf_q   <= res_ovf;
               unf_q   <= res_unf;
               exc_q   <= res_exc;
               dbz_q   <= res_dbz;
            end
            StDone: begin
               if (out_ready) begin
                  ovf_q <= 1'b0;
                  unf_q <= 1'b0;
                  exc_q <= 1'b0;
                  dbz_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign out_x       = out_x_q;
   assign overflow    = ovf_q;
   assign underflow   = unf_q;
   assign exception   = exc_q;
   assign div_by_zero = dbz_q;

endmodule
